division_arbiter: RTL and testbench
===================================

// Module: division_arbiter
// PURPOSE
//  Shares one combinational `division` unit (N-bit dividendo/divisor -> resultado/residuo)
//  between two requesters, using round-robin arbitration. Each side uses a valid/ready handshake.
//  Operands are registered and held stable for SETTLE cycles; quotient/remainder are then
//  captured and held on a single response port until it is accepted.
//  Sits between the processor datapath ports and the shared divider instance (instantiated inside).
// PARAMETERS
//  N       19  operand/result width in bits, passed to the internal `division #(N)`
//  SETTLE  2   cycles operands are held on the divider before capture; legal range 1..15
// PORTS
//  clk             in   1  system clock, rising edge
//  rst             in   1  asynchronous reset, active-high
//  req0_valid      in   1  requester 0 has an operation
//  req0_ready      out  1  requester 0 operation accepted this cycle when valid&ready
//  req0_dividend   in   N  requester 0 dividend
//  req0_divisor    in   N  requester 0 divisor
//  req1_valid      in   1  requester 1 has an operation
//  req1_ready      out  1  requester 1 accept strobe
//  req1_dividend   in   N  requester 1 dividend
//  req1_divisor    in   N  requester 1 divisor
//  resp_valid      out  1  response fields valid
//  resp_ready      in   1  consumer takes the response when valid&ready
//  resp_id         out  1  index of the requester that owns the response
//  resp_quotient   out  N  quotient
//  resp_remainder  out  N  remainder
//  resp_div_zero   out  1  divisor was zero
// BEHAVIOUR
//  - Reset (async, any state):
//    state=IDLE, last_grant=1 (req0 wins first), settle counter=0.
//    All resp_* = 0 and both readyN = 0. Any in-flight operation is dropped and produces no response.
//  - FSM IDLE -> SETTLE -> RESP -> IDLE. Divide-by-zero takes IDLE -> RESP directly.
//  - IDLE:
//    - readyN is combinational and asserted only for the granted requester.
//    - Grant: if only one valid, that one. If both valid, the requester != last_grant.
//    - On accept: latch dividend/divisor/id into operand registers and update last_grant=id.
//    - If divisor != 0: go to SETTLE with counter=0.
//    - If divisor == 0: go to RESP next edge with
//      quotient={N{1'b1}}, remainder=dividend, div_zero=1. The divider output is ignored.
//  - SETTLE:
//    - Divider inputs are driven only from the operand registers, so they are stable.
//    - Counter increments each cycle.
//    - When counter==SETTLE-1: register resultado/residuo into resp_quotient/resp_remainder,
//      div_zero=0, and go to RESP.
//  - RESP:
//    - resp_valid=1; resp_* held constant; both readyN=0.
//    - On resp_valid&resp_ready: clear resp_valid and go to IDLE.
//    - No new accept occurs in the same cycle as resp handshake.
//  - Latency (handshake cycle = 0): resp_valid high in cycle SETTLE+1 (3 at default), or 1 for divisor 0.
//  - Throughput: at most one operation per SETTLE+2 cycles with resp_ready tied high.
//  - Requesters must hold valid and operands until ready. Dropping valid while in IDLE is legal and
//    ungranted. Operand changes after accept have no effect.
//  - Arithmetic is unsigned, N bits. The remainder is always < divisor when divisor != 0.
//  - Both ready outputs are never high in the same cycle.
// TESTING
//  1. req0 25/5, resp_ready=1 -> req0_ready in cycle 0; cycle 3: resp_valid, id=0, q=5, r=0, dz=0.
//  2. req0 28/13 and req1 37/6 valid together from reset -> req0 first (q=2, r=2), then req1 (q=6, r=1).
//     A repeat of both valid -> req1 is NOT re-granted; req0 gets the grant next (alternation).
//  3. req1 37/0 -> resp_valid in cycle 1: id=1, q=0x7FFFF, r=37, dz=1; the divider result is unused.
//  4. req0 0x7FFFF/1 with resp_ready=0 for 5 cycles -> q=0x7FFFF and r=0 held stable;
//     req1 held valid sees ready=0 until the response handshake completes.
//  5. rst pulsed asynchronously mid-SETTLE -> all outputs 0 immediately, no response emitted;
//     the next request completes normally with grant to req0.
//  6. Random 1000-op stress on both ports -> every response matches dividend/divisor and the
//     requester id, with no lost or duplicated operations.

Source files
------------

// File: rtl/division_arbiter.sv
// Round-robin arbiter sharing one combinational unsigned divider between two
// valid/ready requesters, with a single held response port.

module division #(
  parameter int N = 19
) (
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] resultado,
  output logic [N-1:0] residuo
);

  // Restoring long division, one quotient bit per unrolled step, MSB first.
  always_comb begin
    logic [N:0]   rem;
    logic [N-1:0] dvd;
    logic [N-1:0] quo;
    rem = '0;
    dvd = dividendo;
    quo = '0;
    for (int i = 0; i < N; i++) begin
      rem = {rem[N-1:0], dvd[N-1]};
      dvd = {dvd[N-2:0], 1'b0};
      if (rem >= {1'b0, divisor}) begin
        rem = rem - {1'b0, divisor};
        quo = {quo[N-2:0], 1'b1};
      end else begin
        quo = {quo[N-2:0], 1'b0};
      end
    end
    resultado = quo;
    residuo   = rem[N-1:0];
  end

endmodule

module division_arbiter #(
  parameter int N      = 19,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_quotient,
  output logic [N-1:0] resp_remainder,
  output logic         resp_div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t       state, state_next;
  logic         last_grant;
  logic [3:0]   cnt;
  logic [N-1:0] op_dividend, op_divisor;
  logic         op_id;
  logic [N-1:0] div_q, div_r;
  logic         grant1, accept, acc_id;
  logic [N-1:0] acc_dividend, acc_divisor;

  division #(.N(N)) u_div (
    .dividendo (op_dividend),
    .divisor   (op_divisor),
    .resultado (div_q),
    .residuo   (div_r)
  );

  // Grant selection and next state; ready is forced low while reset is held.
  always_comb begin
    state_next   = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    grant1       = 1'b0;
    accept       = 1'b0;
    acc_id       = 1'b0;
    acc_dividend = req0_dividend;
    acc_divisor  = req0_divisor;
    case (state)
      S_IDLE: begin
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        if (!rst) begin
          req0_ready = req0_valid & ~grant1;
          req1_ready = grant1;
        end
        accept = req0_ready | req1_ready;
        if (grant1) begin
          acc_id       = 1'b1;
          acc_dividend = req1_dividend;
          acc_divisor  = req1_divisor;
        end
        if (accept)
          state_next = (acc_divisor == '0) ? S_RESP : S_SETTLE;
      end
      S_SETTLE: if (cnt == LAST_CNT) state_next = S_RESP;
      S_RESP:   if (resp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Operand capture, settle counting and response registers. A zero divisor
  // bypasses the divider and answers straight from the accepted operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant     <= 1'b1;
      cnt            <= '0;
      op_dividend    <= '0;
      op_divisor     <= '0;
      op_id          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_dividend <= acc_dividend;
            op_divisor  <= acc_divisor;
            op_id       <= acc_id;
            last_grant  <= acc_id;
            cnt         <= '0;
            if (acc_divisor == '0) begin
              resp_valid     <= 1'b1;
              resp_id        <= acc_id;
              resp_quotient  <= '1;
              resp_remainder <= acc_dividend;
              resp_div_zero  <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            resp_valid     <= 1'b1;
            resp_id        <= op_id;
            resp_quotient  <= div_q;
            resp_remainder <= div_r;
            resp_div_zero  <= 1'b0;
          end
        end
        S_RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division_arbiter.sv
// Directed and random self-checking bench for division_arbiter
// (N=19, SETTLE=2).

module tb_division_arbiter;

  localparam int N = 19;

  logic         clk, rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic         resp_valid, resp_ready, resp_id, resp_div_zero;
  logic [N-1:0] resp_quotient, resp_remainder;

  int n_checks = 0;
  int n_fails  = 0;

  division_arbiter #(.N(N), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_div_zero(resp_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for resp_valid; lat counts cycles after the first post-accept cycle.
  task automatic wait_resp(output int lat, output logic [2*N+1:0] fields);
    lat = -1;
    fields = '0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid === 1'b1) begin
        lat = i;
        fields = {resp_id, resp_quotient, resp_remainder, resp_div_zero};
        break;
      end
      tick();
    end
  endtask

  function automatic logic [N-1:0] rand_divisor();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel < 4)  return N'($urandom_range(1, 15));
    return N'($urandom_range(1, 524287));
  endfunction

  task automatic test_reset();
    logic [2*N+1:0] f;
    rst = 1'b1;
    req0_valid = 1'b1; req0_dividend = 19'd9;  req0_divisor = 19'd3;
    req1_valid = 1'b1; req1_dividend = 19'd11; req1_divisor = 19'd2;
    resp_ready = 1'b1;
    tick();
    n_checks++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b000) begin
      n_fails++;
      $display("[TB] FAIL reset_handshake: got %b expected 000", {req0_ready, req1_ready, resp_valid});
    end
    f = {resp_id, resp_quotient, resp_remainder, resp_div_zero};
    n_checks++;
    if (f !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_resp_fields: got %0h expected 0", f);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat;
    logic [2*N+1:0] f;
    req0_valid = 1'b1; req0_dividend = 19'd25; req0_divisor = 19'd5;
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    wait_resp(lat, f);
    n_checks++;
    if (lat !== 2) begin
      n_fails++;
      $display("[TB] FAIL single_latency: got %0d expected 2", lat);
    end
    n_checks++;
    if (f !== {1'b0, 19'd5, 19'd0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL single_result: got %0h expected %0h", f, {1'b0, 19'd5, 19'd0, 1'b0});
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL single_resp_clear: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    logic [2*N+1:0] f;
    do_reset();
    resp_ready = 1'b1;
    for (int round = 0; round < 2; round++) begin
      req0_valid = 1'b1; req0_dividend = 19'd28; req0_divisor = 19'd13;
      req1_valid = 1'b1; req1_dividend = 19'd37; req1_divisor = 19'd6;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        n_fails++;
        $display("[TB] FAIL rr_grant_req0_round%0d: got %b expected 10", round, {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      #1;
      n_checks++;
      if (req1_ready !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL rr_busy_ready: got %b expected 0", req1_ready);
      end
      wait_resp(lat, f);
      n_checks++;
      if (f !== {1'b0, 19'd2, 19'd2, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL rr_req0_result: got %0h expected %0h", f, {1'b0, 19'd2, 19'd2, 1'b0});
      end
      tick();
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fails++;
        $display("[TB] FAIL rr_grant_req1: got %b expected 01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 1'b0;
      wait_resp(lat, f);
      n_checks++;
      if (f !== {1'b1, 19'd6, 19'd1, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL rr_req1_result: got %0h expected %0h", f, {1'b1, 19'd6, 19'd1, 1'b0});
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [2*N+1:0] f;
    req1_valid = 1'b1; req1_dividend = 19'd37; req1_divisor = 19'd0;
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fails++;
      $display("[TB] FAIL dz_ready: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    wait_resp(lat, f);
    n_checks++;
    if (lat !== 0) begin
      n_fails++;
      $display("[TB] FAIL dz_latency: got %0d expected 0", lat);
    end
    n_checks++;
    if (f !== {1'b1, 19'h7FFFF, 19'd37, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL dz_result: got %0h expected %0h", f, {1'b1, 19'h7FFFF, 19'd37, 1'b1});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2*N+1:0] f;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_dividend = 19'h7FFFF; req0_divisor = 19'd1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL bp_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_dividend = 19'd100; req1_divisor = 19'd7;
    wait_resp(lat, f);
    n_checks++;
    if ({lat == 2, f} !== {1'b1, 1'b0, 19'h7FFFF, 19'd0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL bp_result: got lat %0d %0h expected lat 2 %0h", lat, f, {1'b0, 19'h7FFFF, 19'd0, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({resp_valid, resp_quotient, resp_remainder, req1_ready} !== {1'b1, 19'h7FFFF, 19'd0, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL bp_hold_%0d: got %0h expected %0h", i,
                 {resp_valid, resp_quotient, resp_remainder, req1_ready}, {1'b1, 19'h7FFFF, 19'd0, 1'b0});
      end
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid, req1_ready} !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL bp_no_accept_on_handshake: got %b expected 10", {resp_valid, req1_ready});
    end
    tick();
    n_checks++;
    if ({resp_valid, req1_ready} !== 2'b01) begin
      n_fails++;
      $display("[TB] FAIL bp_after_handshake: got %b expected 01", {resp_valid, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    wait_resp(lat, f);
    n_checks++;
    if (f !== {1'b1, 19'd14, 19'd2, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL bp_req1_result: got %0h expected %0h", f, {1'b1, 19'd14, 19'd2, 1'b0});
    end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    logic [2*N+1:0] f;
    logic seen;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_dividend = 19'd50; req0_divisor = 19'd7;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL ar_ready: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    f = {resp_id, resp_quotient, resp_remainder, resp_div_zero};
    n_checks++;
    if ({resp_valid, req0_ready, req1_ready, f} !== '0) begin
      n_fails++;
      $display("[TB] FAIL ar_outputs_cleared: got %b/%0h expected all 0",
               {resp_valid, req0_ready, req1_ready}, f);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL ar_dropped_op: got resp_valid seen %b expected 0", seen);
    end
    req0_valid = 1'b1; req0_dividend = 19'd50; req0_divisor = 19'd7;
    req1_valid = 1'b1; req1_dividend = 19'd90; req1_divisor = 19'd9;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL ar_grant_after_reset: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    wait_resp(lat, f);
    n_checks++;
    if (f !== {1'b0, 19'd7, 19'd1, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL ar_req0_result: got %0h expected %0h", f, {1'b0, 19'd7, 19'd1, 1'b0});
    end
    tick();
    tick();
    req1_valid = 1'b0;
    wait_resp(lat, f);
    n_checks++;
    if (f !== {1'b1, 19'd10, 19'd0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL ar_req1_result: got %0h expected %0h", f, {1'b1, 19'd10, 19'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_stress();
    int issued, done;
    logic pend, pend0, last, eg0, eg1, a0, a1;
    logic [2*N+1:0] exp_f, got_f;
    logic [N-1:0] dd, dv;
    do_reset();
    issued = 0; done = 0; pend = 1'b0; last = 1'b1; exp_f = '0;
    for (int cyc = 0; cyc < 40000 && done < 1000; cyc++) begin
      if (!req0_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_dividend = N'($urandom_range(0, 524287)); req0_divisor = rand_divisor();
        issued++;
      end
      if (!req1_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_dividend = N'($urandom_range(0, 524287)); req1_divisor = rand_divisor();
        issued++;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      pend0 = pend;
      eg0 = req0_valid & (~req1_valid | last);
      eg1 = req1_valid & (~req0_valid | ~last);
      n_checks++;
      if (!pend0 && {req0_ready, req1_ready, resp_valid} !== {eg0, eg1, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL stress_idle_cycle%0d: got %b expected %b", cyc,
                 {req0_ready, req1_ready, resp_valid}, {eg0, eg1, 1'b0});
      end else if (pend0 && {req0_ready, req1_ready} !== 2'b00) begin
        n_fails++;
        $display("[TB] FAIL stress_busy_cycle%0d: got %b expected 00", cyc, {req0_ready, req1_ready});
      end
      if (pend0 && resp_valid === 1'b1) begin
        got_f = {resp_id, resp_quotient, resp_remainder, resp_div_zero};
        n_checks++;
        if (got_f !== exp_f) begin
          n_fails++;
          $display("[TB] FAIL stress_resp_%0d: got %0h expected %0h", done, got_f, exp_f);
        end
        if (resp_ready) begin
          pend = 1'b0;
          done++;
        end
      end
      a0 = req0_valid & (req0_ready === 1'b1);
      a1 = req1_valid & (req1_ready === 1'b1);
      if (!pend0 && (a0 || a1)) begin
        dd = a1 ? req1_dividend : req0_dividend;
        dv = a1 ? req1_divisor  : req0_divisor;
        if (dv == '0) exp_f = {a1, {N{1'b1}}, dd, 1'b1};
        else          exp_f = {a1, dd / dv, dd % dv, 1'b0};
        last = a1;
        pend = 1'b1;
      end
      tick();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    n_checks++;
    if (done !== 1000 || pend !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL stress_completion: got %0d done pend %b expected 1000 done pend 0", done, pend);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
    req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_backpressure();
    test_async_reset();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
